// File: rtl/hazard_match_pipe_pkg.sv
// Shared types and constants for the hazard-match pipeline slice.
//   REG_AW     : register address width
//   PC_REG     : PC register address; a source or destination equal to it
//                never produces a match
//   reg_addr_t : one register address
//   src_vec_t  : four reg_addr_t entries, index 0 holds source 1
//   ex_stage_t : Execute-stage register contents
//   mw_stage_t : Memory/Writeback register contents
//   addr_hit() : qualified address compare used by every match flag
package pipe_pkg;

  localparam int REG_AW = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [3:0][REG_AW-1:0] src_vec_t;

  localparam reg_addr_t PC_REG = reg_addr_t'(15);

  typedef struct packed {
    src_vec_t   ra;
    logic [3:0] use_mask;
    reg_addr_t  wa3;
    logic       reg_write;
    logic       mem_to_reg;
  } ex_stage_t;

  typedef struct packed {
    reg_addr_t wa3;
    logic      reg_write;
  } mw_stage_t;

  // A used source hits a destination on exact address equality, except
  // that the PC is always resolved elsewhere and never counts as a hit.
  function automatic logic addr_hit(input reg_addr_t src, input reg_addr_t dst,
                                    input logic used);
    return used && (src == dst) && (src != PC_REG);
  endfunction

endpackage

// File: rtl/hazard_match_pipe_if.sv
// Bundle between decoder/hazard unit and hazard_match_pipe.
//   master : decoder + hazard unit side (drives Decode fields, CondExE, FlushE;
//            receives match flags and stage write/load enables)
//   slave  : hazard_match_pipe side
interface hazard_match_pipe_if;
  import pipe_pkg::*;

  reg_addr_t  RA1D, RA2D, RA3D, RA4D;
  logic [3:0] UseD;
  reg_addr_t  WA3D;
  logic       RegWriteD;
  logic       MemtoRegD;
  logic       CondExE;
  logic       FlushE;

  logic Match_1E_M, Match_2E_M, Match_3E_M, Match_4E_M;
  logic Match_1E_W, Match_2E_W, Match_3E_W, Match_4E_W;
  logic Match_1234D_E;
  logic RegWriteM;
  logic RegWriteW;
  logic MemtoRegE;

  modport master (
    output RA1D, RA2D, RA3D, RA4D, UseD, WA3D, RegWriteD, MemtoRegD,
           CondExE, FlushE,
    input  Match_1E_M, Match_2E_M, Match_3E_M, Match_4E_M,
           Match_1E_W, Match_2E_W, Match_3E_W, Match_4E_W,
           Match_1234D_E, RegWriteM, RegWriteW, MemtoRegE
  );

  modport slave (
    input  RA1D, RA2D, RA3D, RA4D, UseD, WA3D, RegWriteD, MemtoRegD,
           CondExE, FlushE,
    output Match_1E_M, Match_2E_M, Match_3E_M, Match_4E_M,
           Match_1E_W, Match_2E_W, Match_3E_W, Match_4E_W,
           Match_1234D_E, RegWriteM, RegWriteW, MemtoRegE
  );

endinterface

// File: rtl/hazard_match_pipe_stage_reg.sv
// Pipeline stage flop: parameterised width, async active-high reset to 0,
// synchronous clear to 0 (used to load a bubble).
//   clk, reset : clock / async reset
//   clr        : synchronous clear, wins over d
//   d, q       : stage input / registered output
module stage_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every stage
  // samples its input from before the edge, regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else          q <= d;
  end

endmodule

// File: rtl/hazard_match_pipe.sv
// Carries register addresses and write enables through Execute, Memory and
// Writeback and produces the address-match flags the hazard unit consumes.
//   clk   : core clock
//   reset : asynchronous active-high reset, clears every stage
//   bus   : hazard_match_pipe_if.slave (Decode fields, CondExE, FlushE in;
//           Match_* flags, RegWriteM/W, MemtoRegE out)
module hazard_match_pipe
  import pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  hazard_match_pipe_if.slave   bus
);

  src_vec_t  ra_d;
  ex_stage_t ex_d, ex_q;
  mw_stage_t m_d, m_q, w_q;

  logic [3:0] match_m, match_w;
  logic       match_de;

  assign ra_d = {bus.RA4D, bus.RA3D, bus.RA2D, bus.RA1D};

  assign ex_d = '{ra:         ra_d,
                  use_mask:   bus.UseD,
                  wa3:        bus.WA3D,
                  reg_write:  bus.RegWriteD,
                  mem_to_reg: bus.MemtoRegD};

  // FlushE clears the whole Execute slot; only the enables need to be zero,
  // the address fields are don't-care in a bubble.
  stage_reg #(.WIDTH($bits(ex_stage_t))) u_ex (
    .clk(clk), .reset(reset), .clr(bus.FlushE), .d(ex_d), .q(ex_q)
  );

  // A predicated instruction that fails its condition must not write back.
  assign m_d = '{wa3: ex_q.wa3, reg_write: ex_q.reg_write & bus.CondExE};

  stage_reg #(.WIDTH($bits(mw_stage_t))) u_mem (
    .clk(clk), .reset(reset), .clr(1'b0), .d(m_d), .q(m_q)
  );

  stage_reg #(.WIDTH($bits(mw_stage_t))) u_wb (
    .clk(clk), .reset(reset), .clr(1'b0), .d(m_q), .q(w_q)
  );

  // E-stage flags are left ungated by RegWriteM/W; the hazard unit combines
  // them with the enables and applies M-over-W priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    match_m  = '0;
    match_w  = '0;
    match_de = 1'b0;
    for (int i = 0; i < 4; i++) begin
      match_m[i] = addr_hit(ex_q.ra[i], m_q.wa3, ex_q.use_mask[i]);
      match_w[i] = addr_hit(ex_q.ra[i], w_q.wa3, ex_q.use_mask[i]);
      match_de   = match_de | addr_hit(ra_d[i], ex_q.wa3, bus.UseD[i]);
    end
    match_de = match_de & ex_q.reg_write;
  end

  assign bus.Match_1E_M    = match_m[0];
  assign bus.Match_2E_M    = match_m[1];
  assign bus.Match_3E_M    = match_m[2];
  assign bus.Match_4E_M    = match_m[3];
  assign bus.Match_1E_W    = match_w[0];
  assign bus.Match_2E_W    = match_w[1];
  assign bus.Match_3E_W    = match_w[2];
  assign bus.Match_4E_W    = match_w[3];
  assign bus.Match_1234D_E = match_de;
  assign bus.RegWriteM     = m_q.reg_write;
  assign bus.RegWriteW     = w_q.reg_write;
  assign bus.MemtoRegE     = ex_q.mem_to_reg;

endmodule
